// File: rtl/jump_pkg.sv
// jump_pkg
//   Shared definitions for the player jump controller: state encoding
//   (also driven out on the state port) and default tuning constants.
//   Optional feature macro used by mario_jump_ctrl: MARIO_DOUBLE_JUMP_EN.
package jump_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHARGE = 3'd1,
        RISE   = 3'd2,
        FALL   = 3'd3
    } jump_state_e;

    localparam int unsigned CNT_W_DEF    = 7;
    localparam int unsigned HOLD_MAX_DEF = 120;
    localparam int unsigned MIN_JUMP_DEF = 4;

endpackage

// File: rtl/tick_edge_det.sv
// tick_edge_det
//   Rising-edge detector for a button that is only looked at on frame ticks.
//   The previous button level is captured on every tick, so a press is a
//   button that is high now but was low at the last tick.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset
//   tick_i   - one-clk frame enable
//   btn_i    - debounced button, synchronous to clk
//   press_o  - btn_i & ~btn_prev (only meaningful while tick_i is high)
module tick_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_i,
    output logic press_o
);

    logic btn_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q <= 1'b0;
        end else if (tick_i) begin
            btn_prev_q <= btn_i;
        end
    end

    assign press_o = btn_i & ~btn_prev_q;

endmodule

// File: rtl/mario_jump_ctrl.sv
// mario_jump_ctrl
//   Variable-height jump controller. Holding the up button charges a jump,
//   releasing it launches a rise of max(charge, MIN_JUMP) frames followed by
//   a fall of equal length. A ceiling bonk during the rise cuts straight to
//   the fall. Everything advances only on frame ticks.
//   Optional feature: define MARIO_DOUBLE_JUMP_EN to allow one uncharged
//   mid-air jump (rise of max(HOLD_MAX/2, MIN_JUMP) frames) per landing.
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   frame_tick_i    - one-clk enable per frame
//   up_btn_i        - debounced up button
//   bonk_i          - head hit a ceiling (used in RISE only)
//   state_o         - current state (jump_pkg encoding)
//   y_offset_o      - height above ground in pixels
//   charge_lvl_o    - current or last captured hold count
//   airborne_o      - in RISE or FALL
//   rising_o        - in RISE
//   jump_start_o    - one-clk pulse when RISE is entered
//   land_o          - one-clk pulse on FALL -> IDLE
module mario_jump_ctrl
    import jump_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF,
    parameter int unsigned MIN_JUMP = MIN_JUMP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick_i,
    input  logic             up_btn_i,
    input  logic             bonk_i,
    output logic [2:0]       state_o,
    output logic [CNT_W:0]   y_offset_o,
    output logic [CNT_W-1:0] charge_lvl_o,
    output logic             airborne_o,
    output logic             rising_o,
    output logic             jump_start_o,
    output logic             land_o
);

    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] MIN_JUMP_C = CNT_W'(MIN_JUMP);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W:0]   Y_ONE      = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]   Y_MAX      = '1;

    jump_state_e      state_q, state_d;
    logic [CNT_W:0]   y_q, y_d;
    logic [CNT_W-1:0] charge_q, charge_d;
    logic [CNT_W-1:0] rise_q, rise_d;
    logic             js_q, js_d;
    logic             land_q, land_d;
    logic             airborne_q, rising_q;
    logic             press;

`ifdef MARIO_DOUBLE_JUMP_EN
    localparam logic [CNT_W-1:0] DJ_RISE_C =
        ((HOLD_MAX / 2) > MIN_JUMP) ? CNT_W'(HOLD_MAX / 2) : MIN_JUMP_C;
    logic dj_used_q, dj_used_d;
`endif

    tick_edge_det u_up_edge (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (frame_tick_i),
        .btn_i   (up_btn_i),
        .press_o (press)
    );

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        charge_d = charge_q;
        rise_d   = rise_q;
        js_d     = 1'b0;
        land_d   = 1'b0;
`ifdef MARIO_DOUBLE_JUMP_EN
        dj_used_d = dj_used_q;
`endif
        if (frame_tick_i) begin
            case (state_q)
                IDLE: begin
                    if (press) begin
                        state_d  = CHARGE;
                        charge_d = CNT_ONE;
                    end
                end
                CHARGE: begin
                    if (up_btn_i) begin
                        if (charge_q < HOLD_MAX_C) begin
                            charge_d = charge_q + 1'b1;
                        end
                    end else begin
                        state_d = RISE;
                        rise_d  = (charge_q < MIN_JUMP_C) ? MIN_JUMP_C : charge_q;
                        js_d    = 1'b1;
                    end
                end
                RISE: begin
                    if (bonk_i) begin
                        state_d = FALL;
                    end else begin
                        if (y_q != Y_MAX) begin
                            y_d = y_q + 1'b1;
                        end
                        rise_d = rise_q - 1'b1;
                        if (rise_q == CNT_ONE) begin
                            state_d = FALL;
                        end
                    end
                end
                FALL: begin
                    // y = 0 here only after a bonk on the very first rise tick
                    if (y_q <= Y_ONE) begin
                        state_d = IDLE;
                        y_d     = '0;
                        land_d  = 1'b1;
                    end else begin
                        y_d = y_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
`ifdef MARIO_DOUBLE_JUMP_EN
            // The mid-air press wins over bonk, rise/fall stepping and landing
            if ((state_q == RISE || state_q == FALL) && press && !dj_used_q) begin
                state_d   = RISE;
                y_d       = y_q;
                rise_d    = DJ_RISE_C;
                js_d      = 1'b1;
                land_d    = 1'b0;
                dj_used_d = 1'b1;
            end
            if (land_d) begin
                dj_used_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            y_q        <= '0;
            charge_q   <= '0;
            rise_q     <= '0;
            js_q       <= 1'b0;
            land_q     <= 1'b0;
            airborne_q <= 1'b0;
            rising_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            charge_q   <= charge_d;
            rise_q     <= rise_d;
            js_q       <= js_d;
            land_q     <= land_d;
            airborne_q <= (state_d == RISE) || (state_d == FALL);
            rising_q   <= (state_d == RISE);
        end
    end

`ifdef MARIO_DOUBLE_JUMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dj_used_q <= 1'b0;
        end else begin
            dj_used_q <= dj_used_d;
        end
    end
`endif

    assign state_o      = state_q;
    assign y_offset_o   = y_q;
    assign charge_lvl_o = charge_q;
    assign airborne_o   = airborne_q;
    assign rising_o     = rising_q;
    assign jump_start_o = js_q;
    assign land_o       = land_q;

endmodule
